lcd_800_480_timing: RTL and testbench
=====================================

Name: lcd_800_480_timing

Overview:
Video timing generator for the 800x480 parallel-RGB LCD on the Tang Primer 20K dock. It sits directly downstream of the board PLL and runs in the pixel-clock domain. It produces hsync, vsync, data-enable, pixel coordinates and frame/line markers for the pixel-drawing logic and the LCD pins. The pixel_en qualifier allows the block to run from a faster PLL output with a divided pixel rate.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FRONT, 40, horizontal front porch (pixels, >=1)
H_SYNC, 48, hsync pulse width (pixels, >=1)
H_BACK, 40, horizontal back porch (pixels, >=1)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 13, vertical front porch (lines, >=1)
V_SYNC, 3, vsync pulse width (lines, >=1)
V_BACK, 29, vertical back porch (lines, >=1)
HSYNC_POL, 0, 0 = hsync active low, 1 = active high
VSYNC_POL, 0, 0 = vsync active low, 1 = active high
X_W, 10, width of x output; must hold H_TOTAL-1
Y_W, 10, width of y output; must hold V_TOTAL-1

Ports:
clk  input  1  pixel-domain clock from PLL
rst  input  1  asynchronous active-high reset
pixel_en  input  1  advance one pixel on this clk edge when 1
hsync  output  1  horizontal sync, polarity per HSYNC_POL
vsync  output  1  vertical sync, polarity per VSYNC_POL
display_on  output  1  data enable; 1 only in active area
x  output  X_W  horizontal position of the current output pixel
y  output  Y_W  vertical position of the current output pixel
line_start  output  1  one-pixel pulse at x==0 of every line
frame_start  output  1  one-pixel pulse at (0,0)
rgb  output  16  RGB565 test pattern; present only with LCD_TIMING_TEST_PATTERN_EN

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (928). V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Internal h_cnt counts 0..H_TOTAL-1 and v_cnt counts 0..V_TOTAL-1.
- Horizontal phase FSM: ACTIVE (h<800) -> FRONT -> SYNC -> BACK -> ACTIVE. Transitions occur at the phase boundaries of h_cnt.
- Vertical phases use the same order, line-based, and change only when h_cnt wraps.
- Update rule: on a clk edge with pixel_en=1, h_cnt increments. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments; at V_TOTAL-1, v_cnt wraps to 0.
- When pixel_en=0, the counters and all outputs hold their values.
- All outputs are registered decodes of the pre-increment counters, so outputs lag the counters by one enabled edge. All outputs on a given cycle describe the same pixel.
- display_on = (x<H_ACTIVE) && (y<V_ACTIVE).
- hsync is asserted for x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. [840,887].
- vsync is asserted for all pixels of lines y in [V_ACTIVE+V_FRONT, +V_SYNC-1], i.e. [493,495]. vsync edges coincide with x==0.
- x and y report raw counter values, including during blanking.
- line_start = (x==0); frame_start = (x==0 && y==0).
- Reset (asynchronous, immediate, including mid-frame):
  - counters = 0; x = 0; y = 0;
  - display_on = 0, line_start = 0, frame_start = 0, rgb = 0;
  - hsync/vsync at their inactive level (1 for POL=0).
- First enabled edge after reset release: outputs show (0,0) with display_on=1, line_start=1, frame_start=1.
- No other state exists. The next frame is identical; there is no drift.

Optional Feature:
LCD_TIMING_TEST_PATTERN_EN
- Defined: adds the rgb output port with 8 vertical colour bars, each H_ACTIVE/8 = 100 pixels wide. Bar order: white, yellow, cyan, green, magenta, red, blue, black (FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000).
- rgb is registered and aligned with display_on; it is 0 whenever display_on=0.
- Undefined: the rgb port and its logic are absent, and all other behaviour is unchanged.

Test Plan:
- Reset, then pixel_en=1 constantly -> first output (0,0) with display_on=1, frame_start=1. The next frame_start comes exactly 487200 cycles later.
- Line scan -> display_on is high for x 0..799. hsync is low for exactly 48 cycles, starting at x=840 and ending after x=887. Line length is 928 cycles.
- Frame scan -> vsync is low on lines 493..495 only, asserting and deasserting at x==0. display_on is never high for y>=480. y wraps 524->0.
- pixel_en toggling 1,0,0,1 mid-line -> x advances by exactly 2 across the four cycles, and all outputs hold during the 0 cycles.
- Assert rst at (x=500, y=200) for 3 cycles -> outputs go to reset values immediately, without waiting for a clock edge. After release, the first enabled edge gives (0,0) with frame_start=1.
- With LCD_TIMING_TEST_PATTERN_EN defined, line y=10 -> rgb=FFFF at x=0..99, FFE0 at x=100, 0000 at x=799, and 0 at x=800 and beyond.

Source files
------------

// File: rtl/lcd_800_480_timing_if.sv
// rtl/lcd_800_480_timing_if.sv - LCD timing output bundle (rgb present only with LCD_TIMING_TEST_PATTERN_EN)
interface lcd_800_480_timing_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           pixel_en;
  logic           hsync;
  logic           vsync;
  logic           display_on;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           line_start;
  logic           frame_start;
`ifdef LCD_TIMING_TEST_PATTERN_EN
  logic [15:0]    rgb;

  modport master (
    input  pixel_en,
    output hsync, vsync, display_on, x, y, line_start, frame_start, rgb
  );
  modport slave (
    output pixel_en,
    input  hsync, vsync, display_on, x, y, line_start, frame_start, rgb
  );
`else
  modport master (
    input  pixel_en,
    output hsync, vsync, display_on, x, y, line_start, frame_start
  );
  modport slave (
    output pixel_en,
    input  hsync, vsync, display_on, x, y, line_start, frame_start
  );
`endif
endinterface

// File: rtl/lcd_800_480_timing.sv
// rtl/lcd_800_480_timing.sv - 800x480 LCD video timing generator; optional colour bars via LCD_TIMING_TEST_PATTERN_EN
module lcd_800_480_timing #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 48,
  parameter int H_BACK    = 40,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 13,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 29,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int X_W       = 10,
  parameter int Y_W       = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_800_480_timing_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each phase; the phase FSMs step on these boundaries.
  localparam logic [X_W-1:0] H_ACT_END = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] H_FP_END  = X_W'(H_ACTIVE + H_FRONT - 1);
  localparam logic [X_W-1:0] H_SY_END  = X_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] V_FP_END  = Y_W'(V_ACTIVE + V_FRONT - 1);
  localparam logic [Y_W-1:0] V_SY_END  = Y_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);

  localparam logic HS_ACT = (HSYNC_POL != 0);
  localparam logic VS_ACT = (VSYNC_POL != 0);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  phase_t         h_phase_q, h_phase_d, v_phase_q, v_phase_d;
  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_W-1:0] v_cnt_q, v_cnt_d;
  logic           h_wrap, v_wrap;

  logic           hsync_q, vsync_q, display_on_q, line_start_q, frame_start_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  // Next counter values and phases; vertical side only moves on a line wrap.
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    h_phase_d = h_phase_q;
    v_phase_d = v_phase_q;
    if (bus.pixel_en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + X_W'(1);
      case (h_phase_q)
        PH_ACTIVE: if (h_cnt_q == H_ACT_END) h_phase_d = PH_FRONT;
        PH_FRONT:  if (h_cnt_q == H_FP_END)  h_phase_d = PH_SYNC;
        PH_SYNC:   if (h_cnt_q == H_SY_END)  h_phase_d = PH_BACK;
        PH_BACK:   if (h_wrap)               h_phase_d = PH_ACTIVE;
      endcase
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + Y_W'(1);
        case (v_phase_q)
          PH_ACTIVE: if (v_cnt_q == V_ACT_END) v_phase_d = PH_FRONT;
          PH_FRONT:  if (v_cnt_q == V_FP_END)  v_phase_d = PH_SYNC;
          PH_SYNC:   if (v_cnt_q == V_SY_END)  v_phase_d = PH_BACK;
          PH_BACK:   if (v_wrap)               v_phase_d = PH_ACTIVE;
        endcase
      end
    end
  end

  // Counter and phase state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      h_phase_q <= PH_ACTIVE;
      v_phase_q <= PH_ACTIVE;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_phase_q <= h_phase_d;
      v_phase_q <= v_phase_d;
    end
  end

  // Outputs decode the pre-increment counters, so every output describes the same pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else if (bus.pixel_en) begin
      hsync_q       <= (h_phase_q == PH_SYNC) ? HS_ACT : ~HS_ACT;
      vsync_q       <= (v_phase_q == PH_SYNC) ? VS_ACT : ~VS_ACT;
      display_on_q  <= (h_phase_q == PH_ACTIVE) && (v_phase_q == PH_ACTIVE);
      line_start_q  <= (h_cnt_q == '0);
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
      x_q           <= h_cnt_q;
      y_q           <= v_cnt_q;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.display_on  = display_on_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;

`ifdef LCD_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_idx;
  logic [15:0] bar_color;
  logic [15:0] rgb_q;

  // Pick one of eight equal-width bars from the current column.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= X_W'(i * BAR_W)) bar_idx = 3'(i);
    end
    case (bar_idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  end

  // Colour register, blanked with the same qualifier as display_on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
    end else if (bus.pixel_en) begin
      rgb_q <= ((h_phase_q == PH_ACTIVE) && (v_phase_q == PH_ACTIVE)) ? bar_color : 16'h0000;
    end
  end

  assign bus.rgb = rgb_q;
`endif
endmodule

// File: tb/tb_lcd_800_480_timing.sv
// tb/tb_lcd_800_480_timing.sv - directed bench for lcd_800_480_timing (short vertical timing to bound run length)
module tb_lcd_800_480_timing;
  localparam int TV_ACTIVE = 20;
  localparam int TV_FRONT  = 3;
  localparam int TV_SYNC   = 3;
  localparam int TV_BACK   = 4;
  localparam int FRAME_CYC = 928 * 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  lcd_800_480_timing_if #(.X_W(10), .Y_W(10)) bus ();

  lcd_800_480_timing #(
    .V_ACTIVE(TV_ACTIVE), .V_FRONT(TV_FRONT), .V_SYNC(TV_SYNC), .V_BACK(TV_BACK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  int total, line0_cnt, hs_cnt, hs_first, hs_last, de0, de_total, de_bad, ls_cnt, ymax;
  int vs_cnt, vs_first_x, vs_first_y, vs_last_x, vs_last_y;

  initial begin
    bus.pixel_en = 1'b0;
    steps(3);
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_de", 32'(bus.display_on), 0);
    chk("rst_ls", 32'(bus.line_start), 0);
    chk("rst_fs", 32'(bus.frame_start), 0);
    chk("rst_hs", 32'(bus.hsync), 1);
    chk("rst_vs", 32'(bus.vsync), 1);
`ifdef LCD_TIMING_TEST_PATTERN_EN
    chk("rst_rgb", 32'(bus.rgb), 0);
`endif

    rst = 1'b0;
    bus.pixel_en = 1'b1;
    steps(1);
    chk("first_x", 32'(bus.x), 0);
    chk("first_y", 32'(bus.y), 0);
    chk("first_de", 32'(bus.display_on), 1);
    chk("first_ls", 32'(bus.line_start), 1);
    chk("first_fs", 32'(bus.frame_start), 1);

    total = 0; line0_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; de0 = 0;
    de_total = 0; de_bad = 0; ls_cnt = 0; ymax = 0;
    vs_cnt = 0; vs_first_x = -1; vs_first_y = -1; vs_last_x = -1; vs_last_y = -1;
    while (total <= FRAME_CYC + 5) begin
      if (total > 0 && bus.frame_start) break;
      if (bus.y == 0) begin
        line0_cnt++;
        if (!bus.hsync) begin
          if (hs_first < 0) hs_first = int'(bus.x);
          hs_last = int'(bus.x);
          hs_cnt++;
        end
        if (bus.display_on) de0++;
      end
      if (!bus.vsync) begin
        if (vs_first_x < 0) begin
          vs_first_x = int'(bus.x);
          vs_first_y = int'(bus.y);
        end
        vs_last_x = int'(bus.x);
        vs_last_y = int'(bus.y);
        vs_cnt++;
      end
      if (bus.display_on) begin
        de_total++;
        if (bus.y >= 10'(TV_ACTIVE)) de_bad++;
      end
      if (bus.line_start) ls_cnt++;
      if (int'(bus.y) > ymax) ymax = int'(bus.y);
      steps(1);
      total++;
    end
    chk("frame_len", 32'(total), 27840);
    chk("line_len", 32'(line0_cnt), 928);
    chk("hs_low_cnt", 32'(hs_cnt), 48);
    chk("hs_first_x", 32'(hs_first), 840);
    chk("hs_last_x", 32'(hs_last), 887);
    chk("de_line0", 32'(de0), 800);
    chk("de_total", 32'(de_total), 16000);
    chk("de_blank_v", 32'(de_bad), 0);
    chk("ls_cnt", 32'(ls_cnt), 30);
    chk("y_max", 32'(ymax), 29);
    chk("vs_low_cnt", 32'(vs_cnt), 2784);
    chk("vs_first_x", 32'(vs_first_x), 0);
    chk("vs_first_y", 32'(vs_first_y), 23);
    chk("vs_last_x", 32'(vs_last_x), 927);
    chk("vs_last_y", 32'(vs_last_y), 25);
    chk("wrap_fs", 32'(bus.frame_start), 1);
    chk("wrap_y", 32'(bus.y), 0);
    chk("wrap_de", 32'(bus.display_on), 1);

    steps(838);
    chk("pe_x838", 32'(bus.x), 838);
    bus.pixel_en = 1'b1;
    steps(1);
    chk("pe1_x", 32'(bus.x), 839);
    chk("pe1_hs", 32'(bus.hsync), 1);
    bus.pixel_en = 1'b0;
    steps(1);
    chk("pe0a_x", 32'(bus.x), 839);
    chk("pe0a_hs", 32'(bus.hsync), 1);
    chk("pe0a_de", 32'(bus.display_on), 0);
    steps(1);
    chk("pe0b_x", 32'(bus.x), 839);
    chk("pe0b_y", 32'(bus.y), 0);
    bus.pixel_en = 1'b1;
    steps(1);
    chk("pe1b_x", 32'(bus.x), 840);
    chk("pe1b_hs", 32'(bus.hsync), 0);
    bus.pixel_en = 1'b0;
    steps(1);
    chk("pe0c_x", 32'(bus.x), 840);
    chk("pe0c_hs", 32'(bus.hsync), 0);
    bus.pixel_en = 1'b1;

    steps(8940);
    chk("pre_rst_x", 32'(bus.x), 500);
    chk("pre_rst_y", 32'(bus.y), 10);
    chk("pre_rst_de", 32'(bus.display_on), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_x", 32'(bus.x), 0);
    chk("arst_y", 32'(bus.y), 0);
    chk("arst_de", 32'(bus.display_on), 0);
    chk("arst_hs", 32'(bus.hsync), 1);
    steps(3);
    chk("rst_hold_x", 32'(bus.x), 0);
    chk("rst_hold_fs", 32'(bus.frame_start), 0);
    rst = 1'b0;
    steps(1);
    chk("post_rst_x", 32'(bus.x), 0);
    chk("post_rst_y", 32'(bus.y), 0);
    chk("post_rst_fs", 32'(bus.frame_start), 1);

    steps(9280);
    chk("y10_x", 32'(bus.x), 0);
    chk("y10_y", 32'(bus.y), 10);
`ifdef LCD_TIMING_TEST_PATTERN_EN
    chk("rgb_x0", 32'(bus.rgb), 32'hFFFF);
    steps(99);
    chk("rgb_x99", 32'(bus.rgb), 32'hFFFF);
    steps(1);
    chk("rgb_x100", 32'(bus.rgb), 32'hFFE0);
    steps(100);
    chk("rgb_x200", 32'(bus.rgb), 32'h07FF);
    steps(599);
    chk("rgb_x799", 32'(bus.rgb), 32'h0000);
    steps(1);
    chk("rgb_x800", 32'(bus.rgb), 32'h0000);
    chk("rgb_x800_de", 32'(bus.display_on), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
